// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and helpers for the register-file write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hard-wired, so it never appears in a pending mask.
    function automatic logic [NUM_REGS-1:0] onehot_dest(input logic [REG_ADDR_W-1:0] dest);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[dest] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous non-fall-through FIFO of write-back entries with a
//               registered ready and per-slot valid/dest taps.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                push,
    input  wb_entry_t                           push_entry,
    input  logic                                pop,
    output wb_entry_t                           head,
    output logic                                full,
    output logic                                empty,
    output logic                                ready,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_dest
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam int                c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    wb_entry_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [DEPTH-1:0]    r_valid;
    logic                r_ready;
    logic                w_push;
    logic                w_pop;

    assign full   = (r_count == c_FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    // Ready looks at the post-edge count, so a pop from full reopens it one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_FULL_CNT);
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_valid  <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr          <= r_rd_ptr + c_PTR_W'(1);
                    r_valid[r_rd_ptr] <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
                    r_valid[r_wr_ptr] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    assign head        = r_mem[r_rd_ptr];
    assign ready       = r_ready;
    assign entry_valid = r_valid;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_dest
            assign entry_dest[i] = r_mem[i].dest;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Collects ALU and load results, arbitrates them onto the single
//               register-file write port and reports in-flight destinations.
//               WB_RR_ARB_EN selects round-robin instead of MEM-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    output logic              Enable_Register_Write,
    output logic [ADDR_W-1:0] Destination_Write,
    output logic [DATA_W-1:0] Write_Value,
    output logic [31:0]       pending_mask,
    output logic              idle
);

    wb_entry_t                        w_alu_entry;
    wb_entry_t                        w_mem_entry;
    wb_entry_t                        w_alu_head;
    wb_entry_t                        w_mem_head;
    logic                             w_alu_full,  w_mem_full;
    logic                             w_alu_empty, w_mem_empty;
    logic                             w_alu_push,  w_mem_push;
    logic                             w_alu_pop,   w_mem_pop;
    logic                             w_grant_mem;
    logic                             w_any;
    logic [DEPTH-1:0]                 w_alu_vld,   w_mem_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_alu_dst,   w_mem_dst;
    logic [NUM_REGS-1:0]              w_mask;

    logic                             r_we;
    logic [ADDR_W-1:0]                r_dest;
    logic [DATA_W-1:0]                r_data;

    assign w_alu_entry = '{dest: alu_dest, data: alu_data};
    assign w_mem_entry = '{dest: mem_dest, data: mem_data};

    // Writes to r0 complete the handshake but are dropped here.
    assign w_alu_push = alu_valid && alu_ready && !w_alu_full && (alu_dest != '0);
    assign w_mem_push = mem_valid && mem_ready && !w_mem_full && (mem_dest != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (w_alu_push),
        .push_entry  (w_alu_entry),
        .pop         (w_alu_pop),
        .head        (w_alu_head),
        .full        (w_alu_full),
        .empty       (w_alu_empty),
        .ready       (alu_ready),
        .entry_valid (w_alu_vld),
        .entry_dest  (w_alu_dst)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (w_mem_push),
        .push_entry  (w_mem_entry),
        .pop         (w_mem_pop),
        .head        (w_mem_head),
        .full        (w_mem_full),
        .empty       (w_mem_empty),
        .ready       (mem_ready),
        .entry_valid (w_mem_vld),
        .entry_dest  (w_mem_dst)
    );

`ifdef WB_RR_ARB_EN
    logic r_last_mem;

    // Starts as "ALU granted last" so the first tie goes to MEM.
    assign w_grant_mem = !w_mem_empty && (w_alu_empty || !r_last_mem);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_mem <= 1'b0;
        end else if (!flush && !w_mem_empty && !w_alu_empty) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = !w_mem_empty;
`endif

    assign w_any     = !w_mem_empty || !w_alu_empty;
    assign w_mem_pop = w_grant_mem;
    assign w_alu_pop = !w_alu_empty && !w_grant_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
        end else if (flush) begin
            r_we   <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
        end else if (w_any) begin
            r_we   <= 1'b1;
            r_dest <= w_grant_mem ? w_mem_head.dest : w_alu_head.dest;
            r_data <= w_grant_mem ? w_mem_head.data : w_alu_head.data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_vld[i]) w_mask = w_mask | onehot_dest(w_alu_dst[i]);
            if (w_mem_vld[i]) w_mask = w_mask | onehot_dest(w_mem_dst[i]);
        end
        if (r_we) w_mask = w_mask | onehot_dest(r_dest);
    end

    assign Enable_Register_Write = r_we;
    assign Destination_Write     = r_dest;
    assign Write_Value           = r_data;
    assign pending_mask          = w_mask;
    assign idle                  = w_alu_empty && w_mem_empty && !r_we;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Self-checking bench for regfile_writeback against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid, mem_valid, flush;
    logic [ADDR_W-1:0] alu_dest, mem_dest;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready;
    logic              Enable_Register_Write;
    logic [ADDR_W-1:0] Destination_Write;
    logic [DATA_W-1:0] Write_Value;
    logic [31:0]       pending_mask;
    logic              idle;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .alu_valid             (alu_valid),
        .alu_ready             (alu_ready),
        .alu_dest              (alu_dest),
        .alu_data              (alu_data),
        .mem_valid             (mem_valid),
        .mem_ready             (mem_ready),
        .mem_dest              (mem_dest),
        .mem_data              (mem_data),
        .flush                 (flush),
        .Enable_Register_Write (Enable_Register_Write),
        .Destination_Write     (Destination_Write),
        .Write_Value           (Write_Value),
        .pending_mask          (pending_mask),
        .idle                  (idle)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t alu_q[$];
    ent_t mem_q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_dest;
    logic [DATA_W-1:0] m_data;
    logic              m_alu_rdy, m_mem_rdy, m_last_mem;
    bit                last_acc_a, last_acc_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        alu_q.delete();
        mem_q.delete();
        m_we       = 1'b0;
        m_dest     = '0;
        m_data     = '0;
        m_alu_rdy  = 1'b0;
        m_mem_rdy  = 1'b0;
        m_last_mem = 1'b0;
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        foreach (alu_q[i]) m[alu_q[i].dest] = 1'b1;
        foreach (mem_q[i]) m[mem_q[i].dest] = 1'b1;
        if (m_we) m[m_dest] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic compare_all();
        check("strobe",    Enable_Register_Write, m_we);
        check("wdest",     Destination_Write,     m_dest);
        check("wdata",     Write_Value,           m_data);
        check("pending",   pending_mask,          exp_mask());
        check("idle",      idle, (alu_q.size() == 0 && mem_q.size() == 0 && !m_we));
        check("alu_ready", alu_ready,             m_alu_rdy);
        check("mem_ready", mem_ready,             m_mem_rdy);
    endtask

    // One clock: inputs are already stable, model advances at the edge, check at negedge.
    task automatic cycle();
        bit   acc_a, acc_m, take_mem;
        ent_t e;
        acc_a = alu_valid && m_alu_rdy;
        acc_m = mem_valid && m_mem_rdy;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (flush) begin
            alu_q.delete();
            mem_q.delete();
            m_we   = 1'b0;
            m_dest = '0;
            m_data = '0;
        end else begin
            if (alu_q.size() != 0 && mem_q.size() != 0) begin
`ifdef WB_RR_ARB_EN
                take_mem   = !m_last_mem;
                m_last_mem = take_mem;
`else
                take_mem   = 1'b1;
`endif
            end else begin
                take_mem = (mem_q.size() != 0);
            end
            if (alu_q.size() != 0 || mem_q.size() != 0) begin
                e      = take_mem ? mem_q.pop_front() : alu_q.pop_front();
                m_we   = 1'b1;
                m_dest = e.dest;
                m_data = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (acc_a && alu_dest != '0) alu_q.push_back({alu_dest, alu_data});
            if (acc_m && mem_dest != '0) mem_q.push_back({mem_dest, mem_data});
        end
        if (rst) begin
            m_alu_rdy = (alu_q.size() < DEPTH);
            m_mem_rdy = (mem_q.size() < DEPTH);
        end
        last_acc_a = acc_a && rst;
        last_acc_m = acc_m && rst;
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adt,
                         input bit mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdt);
        alu_valid = av; alu_dest = ad; alu_data = adt;
        mem_valid = mv; mem_dest = md; mem_data = mdt;
    endtask

    initial begin
        int guard;
        rst   = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state
        @(negedge clk);
        compare_all();
        cycle();
        rst = 1'b1;
        cycle();
        check("ready_after_release", {alu_ready, mem_ready}, 2'b11);

        // Single ALU write to r9
        drive(1, 5'd9, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        check("t1_pending9", pending_mask, 32'h0000_0200);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        check("t1_strobe", Enable_Register_Write, 1'b1);
        check("t1_dest",   Destination_Write, 5'd9);
        check("t1_data",   Write_Value, 32'hDEADBEEF);
        cycle();
        check("t1_idle", idle, 1'b1);

        // Same-cycle ALU r3 / MEM r4: MEM goes first in both arbitration modes
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        check("t2_first",  Destination_Write, 5'd4);
        cycle();
        check("t2_second", Destination_Write, 5'd3);
        cycle();

        // Eight back-to-back pairs exercise the tie-breaking policy
        for (int k = 0; k < 8; k++) begin
            drive(1, ADDR_W'(k + 1), $urandom, 1, ADDR_W'(k + 17), $urandom);
            guard = 0;
            do begin
                cycle();
                guard++;
                if (last_acc_a) alu_valid = 1'b0;
                if (last_acc_m) mem_valid = 1'b0;
            end while ((alu_valid || mem_valid) && guard < 20);
            check("t3_pair_timeout", guard < 20, 1'b1);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) cycle();

        // DEPTH+2 ALU results, held until accepted
        for (int k = 1; k <= DEPTH + 2; k++) begin
            drive(1, ADDR_W'(k + 8), 32'hA000_0000 + k, 0, 0, 0);
            guard = 0;
            do begin
                cycle();
                guard++;
            end while (!last_acc_a && guard < 20);
            check("t4_accept_timeout", last_acc_a, 1'b1);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) cycle();

        // Write to r0 is swallowed
        drive(1, 5'd0, 32'h12345678, 0, 0, 0);
        cycle();
        check("t5_accepted", last_acc_a, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        check("t5_pending", pending_mask, 32'h0);
        cycle();
        check("t5_nostrobe", Enable_Register_Write, 1'b0);

        // Fill both FIFOs, then flush
        drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
        repeat (10) cycle();
        check("t6_alu_full", alu_ready, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("t6_strobe", Enable_Register_Write, 1'b0);
        check("t6_pending", pending_mask, 32'h0);
        check("t6_idle", idle, 1'b1);
        drive(1, 5'd7, 32'h77, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        check("t6_post_dest", Destination_Write, 5'd7);
        check("t6_post_data", Write_Value, 32'h77);

        // Asynchronous reset in the middle of a burst
        drive(1, 5'd10, 32'hB0, 1, 5'd11, 32'hB1);
        repeat (3) cycle();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t7_strobe", Enable_Register_Write, 1'b0);
        check("t7_dest",   Destination_Write, 5'd0);
        check("t7_data",   Write_Value, 32'h0);
        check("t7_pending", pending_mask, 32'h0);
        check("t7_ready",  {alu_ready, mem_ready}, 2'b00);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        cycle();
        check("t7_ready_back", {alu_ready, mem_ready}, 2'b11);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (!(alu_valid && !last_acc_a)) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_dest  = ADDR_W'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!(mem_valid && !last_acc_m)) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_dest  = ADDR_W'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2 * DEPTH + 2) cycle();
        check("final_idle", idle, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
